// File: rtl/axilite_wdog_bridge_if.sv
// rtl/axilite_wdog_bridge_if.sv - AXI-Lite link bundle shared by the upstream and downstream sides of the bridge
interface axilite_wdog_bridge_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axilite_wdog_bridge.sv
// rtl/axilite_wdog_bridge.sv - AXI-Lite pass-through with per-direction response watchdog (status counters: AXILITE_WDOG_STATUS_EN)
module axilite_wdog_bridge #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axilite_wdog_bridge_if.slave  s_axi,
  axilite_wdog_bridge_if.master m_axi,
`ifdef AXILITE_WDOG_STATUS_EN
  input  logic                  tout_status_clr,
  output logic [15:0]           wr_tout_cnt,
  output logic [15:0]           rd_tout_cnt,
  output logic [31:0]           last_tout_addr,
`endif
  output logic                  wr_timeout_pulse,
  output logic                  rd_timeout_pulse
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FWD   = 3'd1;
  localparam logic [2:0] ST_RESP  = 3'd2;
  localparam logic [2:0] ST_UPRSP = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_FAIL  = 3'd5;

  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [31:0]      ERR_RDATA   = 32'hDEAD_BEEF;

  logic [2:0]       wr_state, rd_state;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic             wr_aw_pend, wr_w_pend, wr_drain, rd_ar_pend, rd_drain;
  logic [31:0]      wr_addr, wr_data, rd_addr, rd_data;
  logic [2:0]       wr_prot, rd_prot;
  logic [3:0]       wr_strb;
  logic [1:0]       wr_resp, rd_resp;
  logic             wr_take, wr_live, wr_hit, wr_tout, wr_drain_hit, wr_fwd_done;
  logic             rd_take, rd_live, rd_hit, rd_tout, rd_drain_hit;

  // A late action response is owed whenever *_drain is set; FWD is only entered after it clears,
  // so a response seen in RESP always belongs to the current transaction.
  assign wr_take      = ((wr_state == ST_IDLE) || (wr_state == ST_DRAIN)) && s_axi.awvalid && s_axi.wvalid;
  assign wr_live      = (wr_state == ST_FWD) || (wr_state == ST_RESP);
  assign wr_hit       = (wr_state == ST_RESP) && m_axi.bvalid;
  assign wr_tout      = wr_live && (wr_cnt == WD_LAST) && !wr_hit;
  assign wr_drain_hit = wr_drain && m_axi.bvalid;
  assign wr_fwd_done  = (!wr_aw_pend || m_axi.awready) && (!wr_w_pend || m_axi.wready);

  assign s_axi.awready = wr_take;
  assign s_axi.wready  = wr_take;
  assign s_axi.bvalid  = (wr_state == ST_UPRSP) || (wr_state == ST_FAIL);
  assign s_axi.bresp   = wr_resp;
  assign m_axi.awvalid = wr_aw_pend;
  assign m_axi.awaddr  = wr_addr;
  assign m_axi.awprot  = wr_prot;
  assign m_axi.wvalid  = wr_w_pend;
  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = wr_strb;
  assign m_axi.bready  = (wr_state == ST_RESP) || wr_drain;

  assign rd_take      = ((rd_state == ST_IDLE) || (rd_state == ST_DRAIN)) && s_axi.arvalid;
  assign rd_live      = (rd_state == ST_FWD) || (rd_state == ST_RESP);
  assign rd_hit       = (rd_state == ST_RESP) && m_axi.rvalid;
  assign rd_tout      = rd_live && (rd_cnt == WD_LAST) && !rd_hit;
  assign rd_drain_hit = rd_drain && m_axi.rvalid;

  assign s_axi.arready = rd_take;
  assign s_axi.rvalid  = (rd_state == ST_UPRSP) || (rd_state == ST_FAIL);
  assign s_axi.rdata   = rd_data;
  assign s_axi.rresp   = rd_resp;
  assign m_axi.arvalid = rd_ar_pend;
  assign m_axi.araddr  = rd_addr;
  assign m_axi.arprot  = rd_prot;
  assign m_axi.rready  = (rd_state == ST_RESP) || rd_drain;

  // Write direction: forward, watch, answer upstream, then absorb any late action response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= ST_IDLE;   wr_cnt  <= '0;  wr_aw_pend <= 1'b0; wr_w_pend <= 1'b0;
      wr_drain <= 1'b0;      wr_addr <= '0;  wr_data    <= '0;   wr_prot   <= '0;
      wr_strb  <= '0;        wr_resp <= '0;  wr_timeout_pulse <= 1'b0;
    end else begin
      wr_timeout_pulse <= wr_tout;
      if (m_axi.awready) wr_aw_pend <= 1'b0;
      if (m_axi.wready)  wr_w_pend  <= 1'b0;
      if (wr_drain_hit)  wr_drain   <= 1'b0;
      if (wr_live)       wr_cnt     <= wr_cnt + CNT_W'(1);
      case (wr_state)
        ST_IDLE: if (wr_take) begin
          wr_addr <= s_axi.awaddr; wr_prot <= s_axi.awprot;
          wr_data <= s_axi.wdata;  wr_strb <= s_axi.wstrb;
          wr_aw_pend <= 1'b1; wr_w_pend <= 1'b1; wr_cnt <= '0; wr_state <= ST_FWD;
        end
        ST_FWD: if (wr_tout) begin
          wr_resp <= RESP_SLVERR; wr_drain <= 1'b1; wr_state <= ST_UPRSP;
        end else if (wr_fwd_done) begin
          wr_state <= ST_RESP;
        end
        ST_RESP: if (wr_hit) begin
          wr_resp <= m_axi.bresp; wr_state <= ST_UPRSP;
        end else if (wr_tout) begin
          wr_resp <= RESP_SLVERR; wr_drain <= 1'b1; wr_state <= ST_UPRSP;
        end
        ST_DRAIN: if (wr_take) begin
          wr_resp <= RESP_SLVERR; wr_state <= ST_FAIL;
        end else if (wr_drain_hit) begin
          wr_state <= ST_IDLE;
        end
        ST_UPRSP, ST_FAIL: if (s_axi.bready) begin
          wr_state <= (wr_drain && !wr_drain_hit) ? ST_DRAIN : ST_IDLE;
        end
        default: wr_state <= ST_IDLE;
      endcase
    end
  end

  // Read direction: same sequencing as writes; error answers carry a recognisable data pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= ST_IDLE; rd_cnt  <= '0; rd_ar_pend <= 1'b0; rd_drain <= 1'b0;
      rd_addr  <= '0;      rd_prot <= '0; rd_data    <= '0;   rd_resp  <= '0;
      rd_timeout_pulse <= 1'b0;
    end else begin
      rd_timeout_pulse <= rd_tout;
      if (m_axi.arready) rd_ar_pend <= 1'b0;
      if (rd_drain_hit)  rd_drain   <= 1'b0;
      if (rd_live)       rd_cnt     <= rd_cnt + CNT_W'(1);
      case (rd_state)
        ST_IDLE: if (rd_take) begin
          rd_addr <= s_axi.araddr; rd_prot <= s_axi.arprot;
          rd_ar_pend <= 1'b1; rd_cnt <= '0; rd_state <= ST_FWD;
        end
        ST_FWD: if (rd_tout) begin
          rd_data <= ERR_RDATA; rd_resp <= RESP_SLVERR; rd_drain <= 1'b1; rd_state <= ST_UPRSP;
        end else if (!rd_ar_pend || m_axi.arready) begin
          rd_state <= ST_RESP;
        end
        ST_RESP: if (rd_hit) begin
          rd_data <= m_axi.rdata; rd_resp <= m_axi.rresp; rd_state <= ST_UPRSP;
        end else if (rd_tout) begin
          rd_data <= ERR_RDATA; rd_resp <= RESP_SLVERR; rd_drain <= 1'b1; rd_state <= ST_UPRSP;
        end
        ST_DRAIN: if (rd_take) begin
          rd_data <= ERR_RDATA; rd_resp <= RESP_SLVERR; rd_state <= ST_FAIL;
        end else if (rd_drain_hit) begin
          rd_state <= ST_IDLE;
        end
        ST_UPRSP, ST_FAIL: if (s_axi.rready) begin
          rd_state <= (rd_drain && !rd_drain_hit) ? ST_DRAIN : ST_IDLE;
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXILITE_WDOG_STATUS_EN
  // Timeout statistics; a timeout in the same cycle as a clear is still recorded, writes win the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_tout_cnt <= '0; rd_tout_cnt <= '0; last_tout_addr <= '0;
    end else begin
      if (tout_status_clr) begin
        wr_tout_cnt <= '0; rd_tout_cnt <= '0; last_tout_addr <= '0;
      end
      if (rd_tout) begin
        rd_tout_cnt    <= tout_status_clr ? 16'd1 : ((&rd_tout_cnt) ? rd_tout_cnt : rd_tout_cnt + 16'd1);
        last_tout_addr <= rd_addr;
      end
      if (wr_tout) begin
        wr_tout_cnt    <= tout_status_clr ? 16'd1 : ((&wr_tout_cnt) ? wr_tout_cnt : wr_tout_cnt + 16'd1);
        last_tout_addr <= wr_addr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axilite_wdog_bridge.sv
// tb/tb_axilite_wdog_bridge.sv - self-checking bench for axilite_wdog_bridge
module tb_axilite_wdog_bridge;
  localparam int T     = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_timeout_pulse, rd_timeout_pulse;
`ifdef AXILITE_WDOG_STATUS_EN
  logic        tout_status_clr;
  logic [15:0] wr_tout_cnt, rd_tout_cnt;
  logic [31:0] last_tout_addr;
`endif
  int checks = 0;
  int errors = 0;

  axilite_wdog_bridge_if s ();
  axilite_wdog_bridge_if m ();

  always #5 clk = ~clk;

  axilite_wdog_bridge #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axi            (s),
    .m_axi            (m),
`ifdef AXILITE_WDOG_STATUS_EN
    .tout_status_clr  (tout_status_clr),
    .wr_tout_cnt      (wr_tout_cnt),
    .rd_tout_cnt      (rd_tout_cnt),
    .last_tout_addr   (last_tout_addr),
`endif
    .wr_timeout_pulse (wr_timeout_pulse),
    .rd_timeout_pulse (rd_timeout_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Action accepts aw at window aw_at, w at w_at, raises bvalid at b_at (windows counted from FWD entry).
  task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        input int aw_at, input int w_at, input int b_at, input logic [1:0] br, input int bdly);
    bit got = 0, rdone = 0, mdone = 0, mhs, shs, ok;
    int gk = -1, pulses = 0, viol = 0;
    logic [1:0] gr = '0;
    s.awvalid = 1'b1; s.wvalid = 1'b1; s.awaddr = a; s.awprot = a[2:0]; s.wdata = d; s.wstrb = st;
    #1 chk("wr_accept", s.awready & s.wready, 1);
    @(posedge clk); #1;
    s.awvalid = 1'b0; s.wvalid = 1'b0;
    for (int k = 0; k < 300 && !(rdone && (mdone || b_at >= NEVER)); k++) begin
      m.awready = (k == aw_at); m.wready = (k == w_at);
      m.bvalid = (k >= b_at) && !mdone; m.bresp = br;
      s.bready = got && (k >= gk + bdly);
      #1;
      if (k == 0) begin
        chk("wr_fwd_addr", m.awaddr, a); chk("wr_fwd_data", m.wdata, d);
        chk("wr_fwd_strb", m.wstrb, st); chk("wr_fwd_prot", m.awprot, a[2:0]);
      end
      if (m.awvalid !== (k <= aw_at)) viol++;
      if (m.wvalid !== (k <= w_at)) viol++;
      if (got && !rdone && !s.bvalid) viol++;
      if (!got && s.bvalid) begin got = 1; gk = k; gr = s.bresp; end
      if (wr_timeout_pulse) pulses++;
      mhs = m.bvalid && m.bready; shs = s.bvalid && s.bready;
      @(posedge clk); #1;
      if (mhs) mdone = 1;
      if (shs) rdone = 1;
    end
    m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; s.bready = 1'b0;
    ok = (b_at <= T - 1);
    chk("wr_got_resp", got, 1);
    chk("wr_latency", gk, ok ? b_at + 1 : T);
    chk("wr_bresp", gr, ok ? br : 2'b10);
    chk("wr_pulses", pulses, ok ? 0 : 1);
    chk("wr_valid_hold", viol, 0);
  endtask

  task automatic rd_txn(input logic [31:0] a, input int ar_at, input int r_at,
                        input logic [31:0] rd, input logic [1:0] rr, input int rdly);
    bit got = 0, rdone = 0, mdone = 0, mhs, shs, ok;
    int gk = -1, pulses = 0, viol = 0;
    logic [31:0] gd = '0;
    logic [1:0] gr = '0;
    s.arvalid = 1'b1; s.araddr = a; s.arprot = a[4:2];
    #1 chk("rd_accept", s.arready, 1);
    @(posedge clk); #1;
    s.arvalid = 1'b0;
    for (int k = 0; k < 300 && !(rdone && (mdone || r_at >= NEVER)); k++) begin
      m.arready = (k == ar_at);
      m.rvalid = (k >= r_at) && !mdone; m.rdata = rd; m.rresp = rr;
      s.rready = got && (k >= gk + rdly);
      #1;
      if (k == 0) begin
        chk("rd_fwd_addr", m.araddr, a); chk("rd_fwd_prot", m.arprot, a[4:2]);
      end
      if (m.arvalid !== (k <= ar_at)) viol++;
      if (got && !rdone && !s.rvalid) viol++;
      if (!got && s.rvalid) begin got = 1; gk = k; gd = s.rdata; gr = s.rresp; end
      if (rd_timeout_pulse) pulses++;
      mhs = m.rvalid && m.rready; shs = s.rvalid && s.rready;
      @(posedge clk); #1;
      if (mhs) mdone = 1;
      if (shs) rdone = 1;
    end
    m.arready = 1'b0; m.rvalid = 1'b0; s.rready = 1'b0;
    ok = (r_at <= T - 1);
    chk("rd_got_resp", got, 1);
    chk("rd_latency", gk, ok ? r_at + 1 : T);
    chk("rd_rdata", gd, ok ? rd : 32'hDEAD_BEEF);
    chk("rd_rresp", gr, ok ? rr : 2'b10);
    chk("rd_pulses", pulses, ok ? 0 : 1);
    chk("rd_valid_hold", viol, 0);
  endtask

  initial begin
    int aw, w, b, ar, r;
    rst_n = 1'b0;
    s.awvalid = 0; s.awaddr = 0; s.awprot = 0; s.wvalid = 0; s.wdata = 0; s.wstrb = 0; s.bready = 0;
    s.arvalid = 0; s.araddr = 0; s.arprot = 0; s.rready = 0;
    m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 0;
    m.arready = 0; m.rvalid = 0; m.rdata = 0; m.rresp = 0;
`ifdef AXILITE_WDOG_STATUS_EN
    tout_status_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s.awready, 0);   chk("rst_arready", s.arready, 0);
    chk("rst_bvalid", s.bvalid, 0);     chk("rst_rvalid", s.rvalid, 0);
    chk("rst_m_awvalid", m.awvalid, 0); chk("rst_m_wvalid", m.wvalid, 0);
    chk("rst_m_arvalid", m.arvalid, 0); chk("rst_m_bready", m.bready, 0);
    chk("rst_m_rready", m.rready, 0);   chk("rst_m_awaddr", m.awaddr, 0);
    chk("rst_m_wdata", m.wdata, 0);     chk("rst_s_rdata", s.rdata, 0);
    chk("rst_pulses", {wr_timeout_pulse, rd_timeout_pulse}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr_txn(32'h10, 32'h1234_5678, 4'hF, 0, 0, 5, 2'b00, 1);
    rd_txn(32'h20, 0, 4, 32'hCAFE_0001, 2'b00, 1);
    wr_txn(32'h14, 32'hA5A5_0014, 4'h1, 2, 1, T - 1, 2'b00, 2);
    rd_txn(32'h24, 1, T - 1, 32'h0000_0024, 2'b00, 1);
    wr_txn(32'h18, 32'h0000_0018, 4'hC, 0, 0, T, 2'b00, 1);

    wr_txn(32'h30, 32'h0BAD_0030, 4'h3, 0, 0, NEVER, 2'b00, 2);
    chk("drain_bready", m.bready, 1);
    s.awvalid = 1'b1; s.wvalid = 1'b1; s.awaddr = 32'h34; s.wdata = 32'h0BAD_0034;
    #1 chk("drain_accept", s.awready & s.wready, 1);
    @(posedge clk); #1;
    s.awvalid = 1'b0; s.wvalid = 1'b0;
    #1;
    chk("fail_bvalid", s.bvalid, 1);   chk("fail_bresp", s.bresp, 2'b10);
    chk("fail_no_fwd", m.awvalid | m.wvalid, 0); chk("fail_no_pulse", wr_timeout_pulse, 0);
    s.bready = 1'b1;
    @(posedge clk); #1;
    s.bready = 1'b0;
    #1 chk("fail_bvalid_drop", s.bvalid, 0);
    m.bvalid = 1'b1; m.bresp = 2'b00;
    #1 chk("late_bready", m.bready, 1);
    @(posedge clk); #1;
    m.bvalid = 1'b0;
    wr_txn(32'h38, 32'h0600_0038, 4'hF, 1, 2, 6, 2'b01, 1);

    rd_txn(32'h50, NEVER, NEVER, 32'h0, 2'b00, 1);
    chk("rd_drain_arvalid", m.arvalid, 1);
    s.arvalid = 1'b1; s.araddr = 32'h54;
    #1 chk("rd_drain_accept", s.arready, 1);
    @(posedge clk); #1;
    s.arvalid = 1'b0;
    #1;
    chk("rd_fail_rvalid", s.rvalid, 1);  chk("rd_fail_rdata", s.rdata, 32'hDEAD_BEEF);
    chk("rd_fail_rresp", s.rresp, 2'b10); chk("rd_fail_addr_held", m.araddr, 32'h50);
    s.rready = 1'b1;
    @(posedge clk); #1;
    s.rready = 1'b0; m.arready = 1'b1;
    @(posedge clk); #1;
    m.arready = 1'b0;
    #1 chk("rd_late_ar_taken", m.arvalid, 0);
    m.rvalid = 1'b1; m.rdata = 32'h1111_2222;
    #1 chk("rd_late_rready", m.rready, 1);
    @(posedge clk); #1;
    m.rvalid = 1'b0;
    rd_txn(32'h58, 1, 4, 32'h5A5A_0058, 2'b00, 1);

    fork
      wr_txn(32'h70, 32'h7070_7070, 4'hF, 1, 0, 3, 2'b00, 1);
      rd_txn(32'h74, 0, 2, 32'h7474_7474, 2'b00, 2);
    join

    for (int i = 0; i < 20; i++) begin
      aw = $urandom_range(3, 0); w = $urandom_range(3, 0); ar = $urandom_range(3, 0);
      b = $urandom_range(T + 3, (aw > w ? aw : w) + 1);
      r = $urandom_range(T + 3, ar + 1);
      fork
        wr_txn($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), aw, w, b, 2'($urandom), $urandom_range(3, 1));
        rd_txn($urandom & 32'hFFFF_FFFC, ar, r, $urandom, 2'($urandom), $urandom_range(3, 1));
      join
    end

    s.awvalid = 1'b1; s.wvalid = 1'b1; s.awaddr = 32'h60; s.wdata = 32'h6060_6060;
    @(posedge clk); #1;
    s.awvalid = 1'b0; s.wvalid = 1'b0;
    #1 chk("pre_rst_awvalid", m.awvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_awvalid", m.awvalid, 0); chk("arst_wvalid", m.wvalid, 0);
    chk("arst_awaddr", m.awaddr, 0);   chk("arst_wdata", m.wdata, 0);
    chk("arst_bvalid", s.bvalid, 0);   chk("arst_bready", m.bready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr_txn(32'h64, 32'h6464_6464, 4'hF, 0, 0, 2, 2'b00, 1);

`ifdef AXILITE_WDOG_STATUS_EN
    tout_status_clr = 1'b1;
    @(posedge clk); #1;
    tout_status_clr = 1'b0;
    repeat (3) wr_txn(32'h40, 32'h4040_4040, 4'hF, 0, 0, T + 2, 2'b00, 1);
    chk("st_wr_cnt", wr_tout_cnt, 3); chk("st_rd_cnt", rd_tout_cnt, 0);
    chk("st_last_addr", last_tout_addr, 32'h40);
    tout_status_clr = 1'b1;
    @(posedge clk); #1;
    tout_status_clr = 1'b0;
    chk("st_clr_wr", wr_tout_cnt, 0); chk("st_clr_addr", last_tout_addr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
